// File: rtl/cache_arbiter_if.sv
// Cache-side and memory-side signal bundle for the I/D cache line arbiter.
// slave is the arbiter's view; master is the view of the caches plus memory.
interface cache_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
);
  logic              i_read;
  logic [ADDR_W-1:0] i_address;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;

  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_address;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;

  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_address;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_resp;

  modport slave (
    input  i_read, i_address, d_read, d_write, d_address, d_wdata,
           pmem_rdata, pmem_resp,
    output i_rdata, i_resp, d_rdata, d_resp,
           pmem_read, pmem_write, pmem_address, pmem_wdata
  );

  modport master (
    output i_read, i_address, d_read, d_write, d_address, d_wdata,
           pmem_rdata, pmem_resp,
    input  i_rdata, i_resp, d_rdata, d_resp,
           pmem_read, pmem_write, pmem_address, pmem_wdata
  );
endinterface

// File: rtl/cache_arbiter.sv
// Round-robin arbiter sharing one physical-memory port between I-cache and D-cache.
// One line transaction in flight; responses return combinationally to the granted cache.
module cache_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
) (
  input  logic            clk,
  input  logic            rst,
  cache_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, RELEASE} state_t;

  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] wdata;
  } mem_req_t;

  state_t   state, state_nxt;
  logic     last_d;
  mem_req_t req_q;

  logic arb, i_pend, d_pend, grant_i, grant_d;

  // Arbitration; in RELEASE the requester just served is masked so a request
  // the cache has not yet dropped is not granted twice.
  always_comb begin
    arb    = (state == IDLE) || (state == RELEASE);
    i_pend = bus.i_read;
    d_pend = bus.d_read | bus.d_write;
    if (state == RELEASE) begin
      if (last_d) d_pend = 1'b0;
      else        i_pend = 1'b0;
    end
    grant_i = arb & i_pend & (~d_pend | last_d);
    grant_d = arb & d_pend & ~grant_i;
  end

  always_comb begin
    state_nxt      = state;
    bus.pmem_read  = 1'b0;
    bus.pmem_write = 1'b0;
    bus.i_resp     = 1'b0;
    bus.d_resp     = 1'b0;
    case (state)
      IDLE, RELEASE: begin
        if (grant_i)      state_nxt = SERVE_I;
        else if (grant_d) state_nxt = SERVE_D;
        else              state_nxt = IDLE;
      end
      SERVE_I: begin
        bus.pmem_read = 1'b1;
        if (bus.pmem_resp) begin
          bus.i_resp = 1'b1;
          state_nxt  = RELEASE;
        end
      end
      SERVE_D: begin
        bus.pmem_read  = ~req_q.wr;
        bus.pmem_write =  req_q.wr;
        if (bus.pmem_resp) begin
          bus.d_resp = 1'b1;
          state_nxt  = RELEASE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      last_d <= 1'b1;
      req_q  <= '0;
    end else begin
      state <= state_nxt;
      if (grant_i) begin
        last_d     <= 1'b0;
        req_q.wr   <= 1'b0;
        req_q.addr <= bus.i_address;
      end else if (grant_d) begin
        // Write wins when the D-cache raises read and write together.
        last_d     <= 1'b1;
        req_q.wr   <= bus.d_write;
        req_q.addr <= bus.d_address;
        if (bus.d_write) req_q.wdata <= bus.d_wdata;
      end
    end
  end

  assign bus.pmem_address = req_q.addr;
  assign bus.pmem_wdata   = req_q.wdata;
  assign bus.i_rdata      = bus.pmem_rdata;
  assign bus.d_rdata      = bus.pmem_rdata;

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter: latency-programmable memory model, grant-order
// scoreboard and cycle-level checks of request hold, response routing and spacing.
module tb_cache_arbiter;

  localparam int AW = 32;
  localparam int LW = 256;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cache_arbiter_if #(.ADDR_W(AW), .LINE_W(LW)) bus ();

  cache_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus)
  );

  typedef struct {
    bit            is_d;
    bit            wr;
    logic [AW-1:0] addr;
    logic [LW-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int mem_lat = 2;
  int mcnt  = 0;
  logic [LW-1:0] rd_pat = '0;

  int start_cyc = 0, last_resp_cyc = 0, last_len = 0, b2b_gap = 0;
  int n_i = 0, n_d = 0;
  bit prev_act = 0, prev_resp = 0, act, start;

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Memory: answers after mem_lat request cycles with fresh random line data.
  always begin
    @(posedge clk); #1;
    if (bus.pmem_read | bus.pmem_write) begin
      mcnt++;
      if (mcnt >= mem_lat) begin
        rd_pat = {$urandom, $urandom, $urandom, $urandom,
                  $urandom, $urandom, $urandom, $urandom};
        bus.pmem_rdata = rd_pat;
        bus.pmem_resp  = 1'b1;
        mcnt = 0;
      end else bus.pmem_resp = 1'b0;
    end else begin
      mcnt = 0;
      bus.pmem_resp = 1'b0;
    end
  end

  // Monitor: pops the expected grant at each transaction start, checks hold and routing.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_act  = 0;
      prev_resp = 0;
    end else begin
      act   = bus.pmem_read | bus.pmem_write;
      start = act && (!prev_act || prev_resp);
      if (start) begin
        chk("min_gap", prev_resp, 0);
        b2b_gap   = cyc - last_resp_cyc;
        start_cyc = cyc;
        chk("grant_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) cur = exp_q.pop_front();
      end
      if (act) begin
        chk("pmem_address", bus.pmem_address, cur.addr);
        chk("pmem_op", {bus.pmem_write, bus.pmem_read}, cur.wr ? 2'b10 : 2'b01);
        if (cur.wr) chk("pmem_wdata", bus.pmem_wdata, cur.data);
      end
      if (act && bus.pmem_resp) begin
        chk("i_resp_route", bus.i_resp, !cur.is_d);
        chk("d_resp_route", bus.d_resp, cur.is_d);
        if (!cur.is_d)   chk("i_rdata", bus.i_rdata, rd_pat);
        else if (!cur.wr) chk("d_rdata", bus.d_rdata, rd_pat);
        n_i += int'(bus.i_resp);
        n_d += int'(bus.d_resp);
        last_resp_cyc = cyc;
        last_len      = cyc - start_cyc + 1;
      end else begin
        chk("no_stray_resp", {bus.i_resp, bus.d_resp}, 2'b00);
      end
      prev_act  = act;
      prev_resp = act && bus.pmem_resp;
    end
  end

  task automatic push(input bit is_d, input bit wr, input logic [AW-1:0] a, input logic [LW-1:0] d);
    exp_t e;
    e.is_d = is_d; e.wr = wr; e.addr = a; e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic edge_drive();
    @(posedge clk); #1;
  endtask

  task automatic wait_resp(input bit is_d, input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(is_d ? bus.d_resp : bus.i_resp) && n < budget);
    chk(is_d ? "d_resp_seen" : "i_resp_seen", is_d ? bus.d_resp : bus.i_resp, 1);
    #1;
  endtask

  initial begin
    logic [LW-1:0] a5, wd;
    int ni0, nd0, n;
    a5 = {32{8'hA5}};
    bus.i_read = 0; bus.i_address = '0;
    bus.d_read = 0; bus.d_write = 0; bus.d_address = '0; bus.d_wdata = '0;
    bus.pmem_rdata = '0; bus.pmem_resp = 0;

    // Reset held with both caches requesting: nothing issued, I wins first tie.
    bus.i_read = 1; bus.i_address = 32'h0000_0100;
    bus.d_read = 1; bus.d_address = 32'h0000_0180;
    push(0, 0, 32'h0000_0100, '0);
    push(1, 0, 32'h0000_0180, '0);
    repeat (3) @(negedge clk);
    chk("rst_ctrl", {bus.pmem_read, bus.pmem_write, bus.i_resp, bus.d_resp}, 4'b0);
    chk("rst_addr", bus.pmem_address, 0);
    chk("rst_wdata", bus.pmem_wdata, 0);
    edge_drive();
    rst_n = 1;
    @(negedge clk);
    chk("pre_grant_read", bus.pmem_read, 0);
    @(negedge clk);
    chk("grant_latency_read", bus.pmem_read, 1);
    chk("grant_latency_addr", bus.pmem_address, 32'h0000_0100);
    wait_resp(0, 20);
    edge_drive(); bus.i_read = 0;
    wait_resp(1, 20);
    edge_drive(); bus.d_read = 0;

    // I read, memory latency 3.
    mem_lat = 3; ni0 = n_i; nd0 = n_d;
    bus.i_read = 1; bus.i_address = 32'h0000_1000;
    push(0, 0, 32'h0000_1000, '0);
    wait_resp(0, 20);
    chk("i_req_len", last_len, 3);
    edge_drive(); bus.i_read = 0;
    repeat (3) edge_drive();
    chk("i_resp_count", n_i - ni0, 1);
    chk("d_resp_idle", n_d - nd0, 0);

    // D write-back.
    mem_lat = 2;
    bus.d_write = 1; bus.d_address = 32'h8000_0040; bus.d_wdata = a5;
    push(1, 1, 32'h8000_0040, a5);
    wait_resp(1, 20);
    edge_drive(); bus.d_write = 0; bus.d_wdata = '0;
    repeat (2) edge_drive();

    // Simultaneous, continuously held: I, D, I, D with R+2 turnaround.
    bus.i_read = 1; bus.i_address = 32'h0000_2000;
    bus.d_read = 1; bus.d_address = 32'h0000_3000;
    push(0, 0, 32'h0000_2000, '0); push(1, 0, 32'h0000_3000, '0);
    push(0, 0, 32'h0000_2000, '0); push(1, 0, 32'h0000_3000, '0);
    wait_resp(0, 20);
    wait_resp(1, 20);
    chk("b2b_i_to_d", b2b_gap, 2);
    wait_resp(0, 20);
    chk("b2b_d_to_i", b2b_gap, 2);
    edge_drive(); bus.i_read = 0;
    wait_resp(1, 20);
    edge_drive(); bus.d_read = 0;
    repeat (3) edge_drive();
    chk("alt_queue_drained", exp_q.size(), 0);

    // Read and write raised together: write is issued.
    wd = {8{$urandom}};
    bus.d_read = 1; bus.d_write = 1; bus.d_address = 32'h0000_4000; bus.d_wdata = wd;
    push(1, 1, 32'h0000_4000, wd);
    wait_resp(1, 20);
    edge_drive(); bus.d_read = 0; bus.d_write = 0;
    repeat (2) edge_drive();

    // I request dropped mid-transaction still completes.
    mem_lat = 4; ni0 = n_i;
    bus.i_read = 1; bus.i_address = 32'h0000_5000;
    push(0, 0, 32'h0000_5000, '0);
    repeat (2) edge_drive();
    bus.i_read = 0;
    wait_resp(0, 20);
    chk("early_drop_resp", n_i - ni0, 1);
    repeat (2) edge_drive();

    // Reset asserted during a D write-back.
    mem_lat = 10;
    wd = {8{$urandom}};
    bus.d_write = 1; bus.d_address = 32'h0000_6000; bus.d_wdata = wd;
    push(1, 1, 32'h0000_6000, wd);
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.pmem_write && n < 20);
    chk("mid_write_started", bus.pmem_write, 1);
    #1 rst_n = 0;
    #1;
    chk("async_write_drop", {bus.pmem_write, bus.pmem_read}, 2'b00);
    chk("async_addr_clear", bus.pmem_address, 0);
    chk("async_wdata_clear", bus.pmem_wdata, 0);
    mem_lat = 2;
    wd = {8{$urandom}};
    bus.d_wdata = wd;
    bus.i_read = 1; bus.i_address = 32'h0000_7000;
    push(0, 0, 32'h0000_7000, '0);
    push(1, 1, 32'h0000_6000, wd);
    edge_drive();
    rst_n = 1;
    wait_resp(0, 20);
    edge_drive(); bus.i_read = 0;
    wait_resp(1, 20);
    edge_drive(); bus.d_write = 0;
    repeat (3) edge_drive();
    chk("final_queue_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
